// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge: carries vscale data-port accesses onto a req/gnt/rvalid memory bus.
// Also applies range, alignment and timeout checks.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef MEM_TYPE_WIDTH
`define MEM_TYPE_WIDTH 3
`endif
module vscale_dmem_bridge #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0001_0000,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dmem_en,
  input  logic                       dmem_wen,
  input  logic [`MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [`XPR_LEN-1:0]        dmem_addr,
  input  logic [`XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic [`XPR_LEN-1:0]        dmem_rdata,
  output logic                       dmem_wait,
  output logic                       dmem_badmem_e,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [`XPR_LEN-3:0]        mem_addr,
  output logic [3:0]                 mem_be,
  output logic [`XPR_LEN-1:0]        mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [`XPR_LEN-1:0]        mem_rdata
);
  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_RESP, ERR} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic [`XPR_LEN-1:0] addr_q, rdata_q, off;
  logic [1:0] size_q;
  logic wen_q, busy, to, bad, accept, unused;
  assign unused = ^dmem_size;
  // Offset wraps for addresses below MEM_BASE, so one compare covers both window edges.
  assign off = dmem_addr - MEM_BASE;
  assign bad = off >= MEM_BYTES || dmem_size[1:0] == 2'd3
            || (dmem_size[1:0] == 2'd1 && dmem_addr[0])
            || (dmem_size[1:0] == 2'd2 && dmem_addr[1:0] != 2'd0);
  assign busy = state == WR || state == RD_REQ || state == RD_RESP;
  assign to = busy && cnt == 8'(TIMEOUT);
  assign mem_req = (state == WR || state == RD_REQ) && !to;
  assign mem_we = state == WR && !to;
  assign mem_be = !mem_req ? 4'h0
                : (!wen_q || size_q == 2'd2) ? 4'hf
                : size_q == 2'd1 ? (addr_q[1] ? 4'hc : 4'h3)
                : 4'b0001 << addr_q[1:0];
  assign mem_addr = addr_q[`XPR_LEN-1:2];
  assign mem_wdata = dmem_wdata_delayed;
  assign dmem_wait = busy && !to && (state == RD_RESP ? !mem_rvalid : state == WR ? !mem_gnt : 1'b1);
  assign dmem_badmem_e = state == ERR || to;
  assign dmem_rdata = state == RD_RESP ? mem_rdata : rdata_q;
  assign accept = dmem_en && !dmem_wait;
  always_comb begin
    state_n = accept ? (bad ? ERR : dmem_wen ? WR : RD_REQ)
            : !dmem_wait ? IDLE
            : (state == RD_REQ && mem_gnt) ? RD_RESP
            : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      addr_q <= '0;
      wen_q <= 1'b0;
      size_q <= 2'd0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= (accept || state_n != state || !busy) ? 8'd0 : cnt + 8'd1;
      if (accept) begin
        addr_q <= dmem_addr;
        wen_q <= dmem_wen;
        size_q <= dmem_size[1:0];
      end
      if (state == RD_RESP && mem_rvalid && !to) rdata_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// tb_vscale_dmem_bridge: directed literal checks plus random traffic against a transaction-level model.
module tb_vscale_dmem_bridge;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic dmem_en = 0, dmem_wen = 0, dmem_wait, dmem_badmem_e;
  logic [2:0] dmem_size = 0;
  logic [31:0] dmem_addr = 0, dmem_wdata_delayed = 0, dmem_rdata, mem_wdata, mem_rdata = 32'hDEAD_BEEF;
  logic mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [29:0] mem_addr;
  logic [3:0] mem_be;
  int vectors = 0, errors = 0;

  vscale_dmem_bridge #(.MEM_BASE(32'h0), .MEM_BYTES(32'h0001_0000), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed), .dmem_rdata(dmem_rdata),
    .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] sz);
    longint unsigned la = a;
    return la >= 64'h1_0000 || sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] byte_en(input bit wr, input logic [1:0] sz, input logic [31:0] a);
    if (!wr || sz == 2'd2) return 4'hf;
    if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'(1 << a[1:0]);
  endfunction

  // Model: one outstanding transaction, whether it was granted, and how long it has waited.
  bit m_busy = 0, m_wr = 0, m_gr = 0, m_err = 0;
  int m_waited = 0;
  logic [31:0] m_addr = 0, m_last = 0;
  logic [1:0] m_size = 0;

  always @(negedge clk) begin
    bit tmo, e_req, e_wait;
    tmo = m_busy && m_waited == TO;
    e_req = m_busy && !m_gr && !tmo;
    e_wait = m_busy && !tmo && (m_wr ? !mem_gnt : !(m_gr && mem_rvalid));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_we", 32'(mem_we), 32'(e_req && m_wr));
    chk("mem_be", 32'(mem_be), e_req ? 32'(byte_en(m_wr, m_size, m_addr)) : 32'h0);
    chk("mem_addr", 32'(mem_addr), m_addr >> 2);
    chk("dmem_wait", 32'(dmem_wait), 32'(e_wait));
    chk("badmem_e", 32'(dmem_badmem_e), 32'(m_err || tmo));
    chk("dmem_rdata", dmem_rdata, (m_busy && !m_wr && m_gr) ? mem_rdata : m_last);
    if (e_req && m_wr) chk("mem_wdata", mem_wdata, dmem_wdata_delayed);
    if (reset) begin
      m_busy = 0; m_err = 0; m_addr = 0; m_last = 0; m_size = 0; m_wr = 0;
    end else begin
      if (m_busy && !m_wr && m_gr && !tmo && mem_rvalid) m_last = mem_rdata;
      if (dmem_en && !e_wait) begin
        m_err = is_bad(dmem_addr, dmem_size[1:0]);
        m_busy = !m_err; m_wr = dmem_wen; m_gr = 0; m_waited = 0;
        m_addr = dmem_addr; m_size = dmem_size[1:0];
      end else if (!e_wait) begin
        m_busy = 0; m_err = 0;
      end else if (!m_wr && !m_gr && mem_gnt) begin
        m_gr = 1; m_waited = 0;
      end else m_waited++;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic en, input logic wen, input logic [2:0] sz, input logic [31:0] a);
    dmem_en = en; dmem_wen = wen; dmem_size = sz; dmem_addr = a;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_be", 32'(mem_be), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst wait", 32'(dmem_wait), 0);
    chk("rst badmem", 32'(dmem_badmem_e), 0);
    chk("rst rdata", dmem_rdata, 0);
    // reset lands while the load waits for rvalid
    cyc; reset = 0; req(1, 0, 3'd2, 32'h40);
    cyc; req(0, 0, 3'd2, 32'h40); mem_gnt = 1;
    cyc; mem_gnt = 0; reset = 1;
    cyc; reset = 0; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("late rvalid wait", 32'(dmem_wait), 0);
    chk("late rvalid badmem", 32'(dmem_badmem_e), 0);
    chk("late rvalid rdata", dmem_rdata, 0);
    chk("late rvalid req", 32'(mem_req), 0);
    cyc; mem_rvalid = 0;
    // byte store
    req(1, 1, 3'd0, 32'h102);
    @(negedge clk); chk("sb accept wait", 32'(dmem_wait), 0);
    cyc; dmem_en = 0; dmem_wdata_delayed = 32'hAABB_CCDD;
    @(negedge clk);
    chk("sb be", 32'(mem_be), 32'h4);
    chk("sb addr", 32'(mem_addr), 32'h40);
    chk("sb req", 32'(mem_req), 1);
    chk("sb wdata", mem_wdata, 32'hAABB_CCDD);
    chk("sb wait1", 32'(dmem_wait), 1);
    cyc; @(negedge clk); chk("sb wait2", 32'(dmem_wait), 1);
    cyc; mem_gnt = 1; @(negedge clk); chk("sb done", 32'(dmem_wait), 0);
    cyc; mem_gnt = 0; @(negedge clk); chk("sb idle req", 32'(mem_req), 0);
    // word load
    cyc; req(1, 0, 3'd2, 32'h10);
    cyc; dmem_en = 0; mem_gnt = 1;
    @(negedge clk); chk("lw wait1", 32'(dmem_wait), 1); chk("lw be", 32'(mem_be), 32'hf);
    cyc; mem_gnt = 0; @(negedge clk); chk("lw wait2", 32'(dmem_wait), 1); chk("lw resp req", 32'(mem_req), 0);
    cyc; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk); chk("lw done", 32'(dmem_wait), 0); chk("lw rdata", dmem_rdata, 32'h1234_5678);
    cyc; mem_rvalid = 0; mem_rdata = 0; @(negedge clk); chk("lw hold", dmem_rdata, 32'h1234_5678);
    // misaligned half, then out-of-window word store accepted in the error cycle
    cyc; req(1, 0, 3'd1, 32'h3);
    cyc; req(1, 1, 3'd2, 32'h1_0000);
    @(negedge clk); chk("err1 badmem", 32'(dmem_badmem_e), 1); chk("err1 wait", 32'(dmem_wait), 0);
    chk("err1 req", 32'(mem_req), 0);
    cyc; dmem_en = 0; @(negedge clk); chk("err2 badmem", 32'(dmem_badmem_e), 1); chk("err2 req", 32'(mem_req), 0);
    cyc; @(negedge clk); chk("err end", 32'(dmem_badmem_e), 0);
    // load then store without a bubble
    cyc; req(1, 0, 3'd2, 32'h20);
    cyc; req(1, 1, 3'd2, 32'h24); mem_gnt = 1; @(negedge clk); chk("b2b wait", 32'(dmem_wait), 1);
    cyc; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk); chk("b2b done", 32'(dmem_wait), 0); chk("b2b rdata", dmem_rdata, 32'hCAFE_F00D);
    cyc; dmem_en = 0; mem_rvalid = 0; mem_gnt = 1; dmem_wdata_delayed = 32'h0BAD_F00D;
    @(negedge clk); chk("b2b req", 32'(mem_req), 1); chk("b2b we", 32'(mem_we), 1);
    chk("b2b addr", 32'(mem_addr), 32'h9); chk("b2b be", 32'(mem_be), 32'hf);
    cyc; mem_gnt = 0;
    // grant never comes
    req(1, 0, 3'd2, 32'h30);
    cyc; dmem_en = 0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); chk("to wait", 32'(dmem_wait), 1);
      cyc;
    end
    @(negedge clk); chk("to wait end", 32'(dmem_wait), 0); chk("to badmem", 32'(dmem_badmem_e), 1);
    chk("to req", 32'(mem_req), 0);
    cyc; @(negedge clk); chk("to after", 32'(dmem_badmem_e), 0);
    for (int i = 0; i < 4000; i++) begin
      cyc;
      reset = $urandom_range(0, 99) == 0;
      dmem_en = $urandom_range(0, 2) != 0;
      dmem_wen = 1'($urandom_range(0, 1));
      dmem_size = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: dmem_addr = $urandom;
        1: dmem_addr = $urandom & 32'h0000_FFFC;
        default: dmem_addr = $urandom & 32'h0000_FFFF;
      endcase
      dmem_wdata_delayed = $urandom;
      mem_gnt = $urandom_range(0, 2) == 0;
      mem_rvalid = $urandom_range(0, 2) == 0;
      mem_rdata = $urandom;
    end
    cyc;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
